light_sequencer: RTL
====================

LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 SHALL have parameter MIN_GRN_SEC, default 5, minimum green time in ticks (legal 0..15).
REQ-002 SHALL have parameter YEL_SEC, default 3, yellow duration in ticks (legal 1..15).
REQ-003 SHALL have parameter ALLRED_SEC, default 1, all-red clearance duration in ticks (legal 1..15).
REQ-004 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port tick  input  1  one-clk-wide 1 Hz enable pulse from the clock generator.
REQ-007 SHALL have port dir_req  input  1  road select from the timer flag; 0 = road 1 green wanted, 1 = road 2 green wanted.
REQ-008 SHALL have ports red1, yel1, grn1  output  1 each  road 1 lamps.
REQ-009 SHALL have ports red2, yel2, grn2  output  1 each  road 2 lamps.
REQ-010 SHALL have port phase  output  3  current state code.
REQ-011 SHALL have port cnt  output  4  current phase down-counter value t.
REQ-012 SHALL have port busy  output  1  high in any yellow or all-red state.

Function
REQ-013 SHALL implement six states: G1=0, Y1=1, R1=2, G2=3, Y2=4, R2=5; phase SHALL equal the state code.
REQ-014 SHALL drive lamps from registered state only: G1 grn1+red2; Y1 yel1+red2; R1 red1+red2; G2 red1+grn2; Y2 red1+yel2; R2 red1+red2; exactly one lamp per road is lit in every state.
REQ-015 SHALL load t on state entry: MIN_GRN_SEC for G1/G2, YEL_SEC for Y1/Y2, ALLRED_SEC for R1/R2.
REQ-016 SHALL evaluate counters and transitions only on clk edges where tick=1; with tick=0, state and t hold regardless of dir_req.
REQ-017 In G1/G2, on tick with t>0: t decrements by 1, no transition.
REQ-018 In G1, on tick with t=0 and dir_req=1: go to Y1; with dir_req=0: stay, t holds at 0 (saturates).
REQ-019 In G2, on tick with t=0 and dir_req=0: go to Y2; with dir_req=1: stay, t holds at 0.
REQ-020 Minimum green SHALL therefore be MIN_GRN_SEC+1 ticks; MIN_GRN_SEC=0 permits exit on the first tick.
REQ-021 In Y/R states, on tick with t>1: t decrements; on tick with t=1: transition Y1->R1, R1->G2, Y2->R2, R2->G1, loading the new state's value.
REQ-022 Each Y/R state SHALL last exactly its parameter in ticks; dir_req changes during Y/R SHALL be ignored and the sequence SHALL complete to the opposite green.
REQ-023 Transition and t load SHALL take effect on the same clk edge as the qualifying tick (one-edge latency); outputs SHALL update on that edge.
REQ-024 busy SHALL be 1 in Y1, R1, Y2, R2 and 0 in G1, G2.
REQ-025 An illegal state code (6, 7) SHALL go to R2 with t=ALLRED_SEC on the next clk edge, independent of tick.

Reset
REQ-026 While rst_n=0, SHALL immediately (asynchronously) force state G1, t=MIN_GRN_SEC, grn1=1, red2=1, all other lamps 0, busy=0, phase=0.
REQ-027 Reset asserted mid-sequence SHALL abandon the sequence with no intermediate yellow; the first tick after release SHALL be evaluated per REQ-016..021.

Verification
REQ-028 Reset (defaults): rst_n=0 -> grn1=1, red2=1, phase=0, cnt=5, busy=0, yel*/grn2/red1=0.
REQ-029 dir_req=1 held after reset: ticks 1-5 -> cnt 4..0 in G1; tick 6 -> Y1 cnt=3 busy=1; ticks 7-9 -> R1 cnt=1 at tick 9; tick 10 -> G2 cnt=5 busy=0.
REQ-030 dir_req 1->0 during Y1 -> R1 then G2 still reached; ticks 1-5 in G2 -> cnt 0; tick 6 in G2 -> Y2 cnt=3; 3 ticks -> R2; 1 tick -> G1 cnt=5.
REQ-031 tick held 0 for 1000 clks with dir_req=1 and cnt=0 in G1 -> no change; next tick -> Y1.
REQ-032 dir_req=0 forever -> G1 persists, cnt saturates at 0, red2 never drops.
REQ-033 rst_n pulsed low in Y2 at cnt=2 -> same-cycle G1, cnt=5, yel2=0, red1=0, grn1=1.

Source files
------------

// File: rtl/light_sequencer.sv
// Two-road traffic light sequencer.
// Green/yellow/all-red cycle paced by a 1 Hz tick, direction chosen by dir_req.
module light_sequencer #(
  parameter int unsigned MIN_GRN_SEC = 5,
  parameter int unsigned YEL_SEC     = 3,
  parameter int unsigned ALLRED_SEC  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       dir_req,
  output logic       red1,
  output logic       yel1,
  output logic       grn1,
  output logic       red2,
  output logic       yel2,
  output logic       grn2,
  output logic [2:0] phase,
  output logic [3:0] cnt,
  output logic       busy
);

  typedef enum logic [2:0] {
    G1 = 3'd0,
    Y1 = 3'd1,
    R1 = 3'd2,
    G2 = 3'd3,
    Y2 = 3'd4,
    R2 = 3'd5
  } state_t;

  localparam logic [3:0] T_GRN = 4'(MIN_GRN_SEC);
  localparam logic [3:0] T_YEL = 4'(YEL_SEC);
  localparam logic [3:0] T_RED = 4'(ALLRED_SEC);

  state_t     state;
  state_t     state_n;
  logic [3:0] t;
  logic [3:0] t_n;

  // State and phase counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= G1;
      t     <= T_GRN;
    end else begin
      state <= state_n;
      t     <= t_n;
    end
  end

  // Next-state and counter logic, evaluated only on tick
  always_comb begin
    state_n = state;
    t_n     = t;
    case (state)
      G1: if (tick) begin
        if (t != 4'd0) begin
          t_n = t - 4'd1;
        end else if (dir_req) begin
          state_n = Y1;
          t_n     = T_YEL;
        end
      end
      G2: if (tick) begin
        if (t != 4'd0) begin
          t_n = t - 4'd1;
        end else if (!dir_req) begin
          state_n = Y2;
          t_n     = T_YEL;
        end
      end
      Y1: if (tick) begin
        if (t > 4'd1) begin
          t_n = t - 4'd1;
        end else begin
          state_n = R1;
          t_n     = T_RED;
        end
      end
      R1: if (tick) begin
        if (t > 4'd1) begin
          t_n = t - 4'd1;
        end else begin
          state_n = G2;
          t_n     = T_GRN;
        end
      end
      Y2: if (tick) begin
        if (t > 4'd1) begin
          t_n = t - 4'd1;
        end else begin
          state_n = R2;
          t_n     = T_RED;
        end
      end
      R2: if (tick) begin
        if (t > 4'd1) begin
          t_n = t - 4'd1;
        end else begin
          state_n = G1;
          t_n     = T_GRN;
        end
      end
      default: begin
        state_n = R2;
        t_n     = T_RED;
      end
    endcase
  end

  // Lamp and status decode from the registered state
  always_comb begin
    red1 = 1'b0;
    yel1 = 1'b0;
    grn1 = 1'b0;
    red2 = 1'b0;
    yel2 = 1'b0;
    grn2 = 1'b0;
    busy = 1'b1;
    case (state)
      G1: begin
        grn1 = 1'b1;
        red2 = 1'b1;
        busy = 1'b0;
      end
      Y1: begin
        yel1 = 1'b1;
        red2 = 1'b1;
      end
      G2: begin
        red1 = 1'b1;
        grn2 = 1'b1;
        busy = 1'b0;
      end
      Y2: begin
        red1 = 1'b1;
        yel2 = 1'b1;
      end
      default: begin
        red1 = 1'b1;
        red2 = 1'b1;
      end
    endcase
  end

  assign phase = state;
  assign cnt   = t;

endmodule
